// File: rtl/crossbar_pkg.sv
// Shared encodings and defaults for the 2x2 crossbar and its input scheduler.
//   CTRL_*  : crossbar select (straight = in1->out1/in2->out2, cross = swapped)
//   DEST_*  : destination bit carried with every request word
//   DATA_W  : default crossbar port width
//   DEPTH   : default per-input FIFO depth (power of two, >= 2)
package crossbar_pkg;

  localparam int DATA_W = 4;
  localparam int DEPTH  = 4;

  localparam logic CTRL_STRAIGHT = 1'b0;
  localparam logic CTRL_CROSS    = 1'b1;
  localparam logic DEST_OUT1     = 1'b0;
  localparam logic DEST_OUT2     = 1'b1;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } arb_state_t;

  // A word from in1 reaches its destination straight when dest = out1.
  // A word from in2 reaches its destination straight when dest = out2.
  function automatic logic ctrl_sel(input logic dest, input logic from_in2);
    return dest ^ from_in2;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO with extra-MSB wrap pointers.
//   clk, rst_n : clock, asynchronous active-low reset (pointers only)
//   i_push     : write i_data (ignored while full)
//   i_pop      : drop head (ignored while empty)
//   o_full     : no free slot; a same-cycle pop does not clear it
//   o_empty    : no stored word
//   o_head     : oldest stored word (registered storage, no bypass)
module sync_fifo #(
  parameter int WIDTH = 5,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_pop,
  output logic             o_full,
  output logic             o_empty,
  output logic [WIDTH-1:0] o_head
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW:0]      r_wr_ptr;
  logic [AW:0]      r_rd_ptr;
  logic             w_wr_en;
  logic             w_rd_en;

  assign o_empty = (r_wr_ptr == r_rd_ptr);
  assign o_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                   (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign w_wr_en = i_push && !o_full;
  assign w_rd_en = i_pop && !o_empty;
  assign o_head  = r_mem[r_rd_ptr[AW-1:0]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_wr_en) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_rd_en) r_rd_ptr <= r_rd_ptr + 1'b1;
    end
  end

  // Storage is data only; emptiness is tracked by the pointers.
  always_ff @(posedge clk) begin
    if (w_wr_en) r_mem[r_wr_ptr[AW-1:0]] <= i_data;
  end

endmodule

// File: rtl/crossbar_2x2_sched.sv
// Input scheduler for the 2x2 crossbar: two request FIFOs, round-robin
// conflict arbitration and a registered launch stage driving the crossbar.
//   clk, rst_n              : clock, asynchronous active-low reset
//   inN_valid/ready/data/dest : upstream request stream N (dest 0 = out1)
//   xb_in1, xb_in2, control : registered crossbar inputs and select
//   outK_valid/ready        : per-output handshake toward downstream
module crossbar_2x2_sched #(
  parameter int DATA_W = 4,
  parameter int DEPTH  = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in1_valid,
  output logic              in1_ready,
  input  logic [DATA_W-1:0] in1_data,
  input  logic              in1_dest,
  input  logic              in2_valid,
  output logic              in2_ready,
  input  logic [DATA_W-1:0] in2_data,
  input  logic              in2_dest,
  output logic [DATA_W-1:0] xb_in1,
  output logic [DATA_W-1:0] xb_in2,
  output logic              control,
  output logic              out1_valid,
  input  logic              out1_ready,
  output logic              out2_valid,
  input  logic              out2_ready
);

  import crossbar_pkg::*;

  localparam int FW = DATA_W + 1;

  logic              w_full1, w_empty1, w_full2, w_empty2;
  logic [FW-1:0]     w_head1, w_head2;
  logic              w_dest1, w_dest2;
  logic [DATA_W-1:0] w_data1, w_data2;
  logic              w_free, w_take1, w_take2, w_rr_nxt;
  arb_state_t        r_state, w_state_nxt;
  logic              r_rr_ptr;

  logic [DATA_W-1:0] r_xb1_p1, r_xb2_p1;
  logic              r_ctrl_p1, r_vld1_p1, r_vld2_p1;

  sync_fifo #(.WIDTH(FW), .DEPTH(DEPTH)) u_fifo1 (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (in1_valid),
    .i_data  ({in1_dest, in1_data}),
    .i_pop   (w_take1),
    .o_full  (w_full1),
    .o_empty (w_empty1),
    .o_head  (w_head1)
  );

  sync_fifo #(.WIDTH(FW), .DEPTH(DEPTH)) u_fifo2 (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (in2_valid),
    .i_data  ({in2_dest, in2_data}),
    .i_pop   (w_take2),
    .o_full  (w_full2),
    .o_empty (w_empty2),
    .o_head  (w_head2)
  );

  assign in1_ready = !w_full1;
  assign in2_ready = !w_full2;
  assign w_dest1   = w_head1[DATA_W];
  assign w_data1   = w_head1[DATA_W-1:0];
  assign w_dest2   = w_head2[DATA_W];
  assign w_data2   = w_head2[DATA_W-1:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= ST_IDLE;
      r_rr_ptr <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_rr_ptr <= w_rr_nxt;
    end
  end

  // The stage moves as a whole: it advances only when every occupied
  // output is being accepted, so control never changes under a held word.
  always_comb begin
    w_take1     = 1'b0;
    w_take2     = 1'b0;
    w_rr_nxt    = r_rr_ptr;
    w_state_nxt = r_state;
    w_free      = (r_state == ST_IDLE) ||
                  ((!r_vld1_p1 || out1_ready) && (!r_vld2_p1 || out2_ready));
    if (w_free) begin
      if (!w_empty1 && !w_empty2) begin
        if (w_dest1 != w_dest2) begin
          w_take1 = 1'b1;
          w_take2 = 1'b1;
        end else begin
          w_take1  = !r_rr_ptr;
          w_take2  = r_rr_ptr;
          w_rr_nxt = !r_rr_ptr;
        end
      end else begin
        w_take1 = !w_empty1;
        w_take2 = !w_empty2;
      end
      w_state_nxt = (w_take1 || w_take2) ? ST_BUSY : ST_IDLE;
    end
  end

  // ---- launch stage (p1): registered crossbar inputs ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_xb1_p1  <= '0;
      r_xb2_p1  <= '0;
      r_ctrl_p1 <= CTRL_STRAIGHT;
      r_vld1_p1 <= 1'b0;
      r_vld2_p1 <= 1'b0;
    end else if (w_free) begin
      r_vld1_p1 <= (w_take1 && (w_dest1 == DEST_OUT1)) ||
                   (w_take2 && (w_dest2 == DEST_OUT1));
      r_vld2_p1 <= (w_take1 && (w_dest1 == DEST_OUT2)) ||
                   (w_take2 && (w_dest2 == DEST_OUT2));
      // With two launches the dests differ, so in1's dest decides control.
      if (w_take1) begin
        r_xb1_p1  <= w_data1;
        r_ctrl_p1 <= ctrl_sel(w_dest1, 1'b0);
      end else if (w_take2) begin
        r_ctrl_p1 <= ctrl_sel(w_dest2, 1'b1);
      end
      if (w_take2) r_xb2_p1 <= w_data2;
    end
  end

  assign xb_in1     = r_xb1_p1;
  assign xb_in2     = r_xb2_p1;
  assign control    = r_ctrl_p1;
  assign out1_valid = r_vld1_p1;
  assign out2_valid = r_vld2_p1;

endmodule

// File: tb/tb_crossbar_2x2_sched.sv
module tb_crossbar_2x2_sched;

  import crossbar_pkg::*;

  logic              clk;
  logic              rst_n;
  logic              in1_valid, in2_valid;
  logic              in1_ready, in2_ready;
  logic [DATA_W-1:0] in1_data, in2_data;
  logic              in1_dest, in2_dest;
  logic [DATA_W-1:0] xb_in1, xb_in2;
  logic              control;
  logic              out1_valid, out2_valid;
  logic              out1_ready, out2_ready;

  crossbar_2x2_sched #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in1_valid  (in1_valid),
    .in1_ready  (in1_ready),
    .in1_data   (in1_data),
    .in1_dest   (in1_dest),
    .in2_valid  (in2_valid),
    .in2_ready  (in2_ready),
    .in2_data   (in2_data),
    .in2_dest   (in2_dest),
    .xb_in1     (xb_in1),
    .xb_in2     (xb_in2),
    .control    (control),
    .out1_valid (out1_valid),
    .out1_ready (out1_ready),
    .out2_valid (out2_valid),
    .out2_ready (out2_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  // Reference: each input stream is an ordered queue of {dest, data} words
  // accepted upstream; every delivered word must be the oldest of its stream.
  logic [DATA_W:0]   q_exp1[$];
  logic [DATA_W:0]   q_exp2[$];
  logic [DATA_W-1:0] log1[$];
  logic [DATA_W-1:0] log2[$];
  int                logc1[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // A delivered word on output k comes from in1 when routed straight to out1
  // or crossed to out2.
  task automatic sb_deliver(input int k);
    logic              src;
    logic [DATA_W-1:0] word;
    logic [DATA_W:0]   exp;
    src  = (k == 1) ? (control == CTRL_CROSS) : (control == CTRL_STRAIGHT);
    word = src ? xb_in2 : xb_in1;
    if (k == 1) begin
      log1.push_back(word);
      logc1.push_back(cyc);
    end else begin
      log2.push_back(word);
    end
    if ((src && q_exp2.size() == 0) || (!src && q_exp1.size() == 0)) begin
      n_checks++;
      n_fail++;
      $display("FAIL out%0d_spurious: got word %0h, expected none outstanding from in%0d",
               k, word, int'(src) + 1);
    end else begin
      if (src) exp = q_exp2.pop_front();
      else     exp = q_exp1.pop_front();
      check($sformatf("out%0d_data", k), 32'(word), 32'(exp[DATA_W-1:0]));
      check($sformatf("out%0d_dest", k), 32'(exp[DATA_W]), k - 1);
    end
  endtask

  // Monitor: samples at the falling edge, where inputs and outputs are stable
  // and show exactly what the next rising edge will act on.
  initial begin : monitor
    logic              stall_prev;
    logic [DATA_W-1:0] s_xb1, s_xb2;
    logic              s_ctrl, s_v1, s_v2, free;
    stall_prev = 1'b0;
    forever begin
      @(negedge clk);
      cyc++;
      if (!rst_n) begin
        stall_prev = 1'b0;
      end else begin
        if (stall_prev) begin
          check("hold_xb_in1", 32'(xb_in1), 32'(s_xb1));
          check("hold_xb_in2", 32'(xb_in2), 32'(s_xb2));
          check("hold_control", 32'(control), 32'(s_ctrl));
          check("hold_out1_valid", 32'(out1_valid), 32'(s_v1));
          check("hold_out2_valid", 32'(out2_valid), 32'(s_v2));
        end
        free       = (!out1_valid || out1_ready) && (!out2_valid || out2_ready);
        stall_prev = !free;
        s_xb1 = xb_in1; s_xb2 = xb_in2; s_ctrl = control;
        s_v1 = out1_valid; s_v2 = out2_valid;
        if (free && out1_valid) sb_deliver(1);
        if (free && out2_valid) sb_deliver(2);
        if (in1_valid && in1_ready) q_exp1.push_back({in1_dest, in1_data});
        if (in2_valid && in2_ready) q_exp2.push_back({in2_dest, in2_data});
      end
    end
  end

  initial begin : watchdog
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic idle_inputs();
    in1_valid = 1'b0; in2_valid = 1'b0;
    in1_data  = '0;   in2_data  = '0;
    in1_dest  = 1'b0; in2_dest  = 1'b0;
  endtask

  // Holds in1 valid until accepted; returns just after the accepting edge.
  task automatic push1(input logic [DATA_W-1:0] d, input logic dst);
    bit ok;
    ok = 1'b0;
    in1_valid = 1'b1; in1_data = d; in1_dest = dst;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (in1_ready) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      n_checks++;
      n_fail++;
      $display("FAIL push1_timeout: got in1_ready=0 for 50 cycles, expected 1");
    end
    @(posedge clk);
    #2;
    in1_valid = 1'b0;
  endtask

  task automatic rand_phase(input int n);
    repeat (n) begin
      in1_valid  = 1'($urandom_range(0, 1));
      in2_valid  = 1'($urandom_range(0, 1));
      in1_data   = DATA_W'($urandom);
      in2_data   = DATA_W'($urandom);
      in1_dest   = 1'($urandom);
      in2_dest   = 1'($urandom);
      out1_ready = ($urandom_range(0, 3) != 0);
      out2_ready = ($urandom_range(0, 3) != 0);
      tick(1);
    end
  endtask

  initial begin : stimulus
    rst_n = 1'b0;
    idle_inputs();
    out1_ready = 1'b1;
    out2_ready = 1'b1;
    tick(3);
    check("rst_in1_ready", 32'(in1_ready), 1);
    check("rst_in2_ready", 32'(in2_ready), 1);
    check("rst_out1_valid", 32'(out1_valid), 0);
    check("rst_out2_valid", 32'(out2_valid), 0);
    check("rst_control", 32'(control), 32'(CTRL_STRAIGHT));
    check("rst_xb_in1", 32'(xb_in1), 0);
    check("rst_xb_in2", 32'(xb_in2), 0);
    rst_n = 1'b1;
    tick(2);

    // Straight: both words visible two edges after being presented.
    in1_valid = 1'b1; in1_data = 4'h3; in1_dest = DEST_OUT1;
    in2_valid = 1'b1; in2_data = 4'h5; in2_dest = DEST_OUT2;
    tick(1);
    idle_inputs();
    @(posedge clk);
    @(negedge clk);
    check("straight_control", 32'(control), 32'(CTRL_STRAIGHT));
    check("straight_xb_in1", 32'(xb_in1), 32'h3);
    check("straight_xb_in2", 32'(xb_in2), 32'h5);
    check("straight_out1_valid", 32'(out1_valid), 1);
    check("straight_out2_valid", 32'(out2_valid), 1);
    @(negedge clk);
    check("straight_out1_drop", 32'(out1_valid), 0);
    check("straight_out2_drop", 32'(out2_valid), 0);
    tick(1);

    // Cross.
    in1_valid = 1'b1; in1_data = 4'hA; in1_dest = DEST_OUT2;
    in2_valid = 1'b1; in2_data = 4'hB; in2_dest = DEST_OUT1;
    tick(1);
    idle_inputs();
    @(posedge clk);
    @(negedge clk);
    check("cross_control", 32'(control), 32'(CTRL_CROSS));
    check("cross_xb_in1", 32'(xb_in1), 32'hA);
    check("cross_xb_in2", 32'(xb_in2), 32'hB);
    check("cross_out1_valid", 32'(out1_valid), 1);
    check("cross_out2_valid", 32'(out2_valid), 1);
    tick(3);

    // Conflict: round-robin alternates, starting with in1.
    log1.delete(); log2.delete(); logc1.delete();
    in1_valid = 1'b1; in1_data = 4'h1; in1_dest = DEST_OUT1;
    in2_valid = 1'b1; in2_data = 4'h8; in2_dest = DEST_OUT1;
    tick(1);
    in1_data = 4'h2; in2_data = 4'h9;
    tick(1);
    idle_inputs();
    tick(8);
    check("conflict_out1_count", log1.size(), 4);
    check("conflict_out2_count", log2.size(), 0);
    if (log1.size() == 4) begin
      check("conflict_word0", 32'(log1[0]), 32'h1);
      check("conflict_word1", 32'(log1[1]), 32'h8);
      check("conflict_word2", 32'(log1[2]), 32'h2);
      check("conflict_word3", 32'(log1[3]), 32'h9);
      for (int i = 0; i < 3; i++)
        check($sformatf("conflict_gap%0d", i), logc1[i+1] - logc1[i], 1);
    end

    // Backpressure on out1 while in1 streams words 0..5.
    log1.delete();
    out1_ready = 1'b0;
    for (int w = 0; w < 5; w++) push1(DATA_W'(w), DEST_OUT1);
    @(negedge clk);
    check("bp_in1_ready_full", 32'(in1_ready), 0);
    check("bp_stage_valid", 32'(out1_valid), 1);
    check("bp_stage_word", 32'(xb_in1), 0);
    check("bp_stage_control", 32'(control), 32'(CTRL_STRAIGHT));
    tick(1);
    out1_ready = 1'b1;
    push1(DATA_W'(5), DEST_OUT1);
    tick(10);
    check("bp_out1_count", log1.size(), 6);
    if (log1.size() == 6)
      for (int w = 0; w < 6; w++)
        check($sformatf("bp_word%0d", w), 32'(log1[w]), w);

    // Single source on in2: straight to out2, xb_in1 keeps the last word (5).
    in2_valid = 1'b1; in2_data = 4'h7; in2_dest = DEST_OUT2;
    tick(1);
    idle_inputs();
    @(posedge clk);
    @(negedge clk);
    check("single_control", 32'(control), 32'(CTRL_STRAIGHT));
    check("single_xb_in2", 32'(xb_in2), 32'h7);
    check("single_out2_valid", 32'(out2_valid), 1);
    check("single_out1_valid", 32'(out1_valid), 0);
    check("single_xb_in1_hold", 32'(xb_in1), 32'h5);
    tick(2);

    // Random traffic, then an asynchronous reset in the middle of it.
    rand_phase(1500);
    out1_ready = 1'b0;
    in1_valid = 1'b1; in1_dest = DEST_OUT1;
    tick(3);
    rst_n = 1'b0;
    #1;
    check("arst_out1_valid", 32'(out1_valid), 0);
    check("arst_out2_valid", 32'(out2_valid), 0);
    check("arst_in1_ready", 32'(in1_ready), 1);
    check("arst_in2_ready", 32'(in2_ready), 1);
    check("arst_control", 32'(control), 32'(CTRL_STRAIGHT));
    q_exp1.delete();
    q_exp2.delete();
    idle_inputs();
    out1_ready = 1'b1;
    out2_ready = 1'b1;
    tick(2);
    rst_n = 1'b1;
    tick(2);

    rand_phase(800);
    idle_inputs();
    out1_ready = 1'b1;
    out2_ready = 1'b1;
    tick(20);
    check("drain_in1_left", q_exp1.size(), 0);
    check("drain_in2_left", q_exp2.size(), 0);
    check("drain_out1_valid", 32'(out1_valid), 0);
    check("drain_out2_valid", 32'(out2_valid), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
